mpsoc_dbg_wb_target_mem: RTL and testbench
==========================================

Name: mpsoc_dbg_wb_target_mem

Overview:
- Wishbone B3 target (responder) memory that sits on the debug unit's Wishbone master bus as the slave end of the cyc/stb/cti/bte/we/adr/sel/dat/ack/err interface.
- Serves as the debug system memory model and small on-chip scratch RAM.
- Supports classic cycles and incrementing bursts with linear and wrap-4/8/16 addressing, byte lanes, and error response for out-of-window or misaligned addresses.

Parameters:
- ADDR_WIDTH, 32: Wishbone address width.
- DATA_WIDTH, 32: Wishbone data width (multiple of 8).
- DEPTH, 1024: number of DATA_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*DATA_WIDTH/8 aligned.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst; others treated as classic.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_sel_i  in  DATA_WIDTH/8  byte lane enables.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.

Behaviour:
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, burst state IDLE. RAM contents are not reset.
- Definitions: OFF = log2(DATA_WIDTH/8).
  - hit = BASE_ADDR <= adr < BASE_ADDR + DEPTH*2^OFF.
  - misaligned = adr[OFF-1:0] != 0.
  - req = cyc & stb & ~ack & ~err.
- FSM IDLE:
  - On req with ~hit or misaligned: wb_err_o=1 for exactly one cycle next cycle. No RAM write. Stay IDLE.
  - On req with a good address: wb_ack_o=1 next cycle (1 wait state). Read data at adr is on wb_dat_o in the same ack cycle.
  - If cti=010, go to BURST with pred_adr = next(adr, bte). Otherwise ack drops after one cycle and the FSM stays IDLE.
- FSM BURST:
  - Ack stays high every cycle while cyc & stb & cti=010 & adr==pred_adr & hit (zero-wait beats).
  - Each acked beat advances pred_adr; read data is prefetched at pred_adr so it is valid with the ack.
  - cti=111 beat: acked normally, then ack=0 next cycle, back to IDLE.
  - Any of the following drops ack next cycle and returns to IDLE; no write occurs for that cycle: adr != pred_adr, stb=0, cyc=0, or cti is neither 010 nor 111. A mismatched request is then served as a new IDLE access.
  - Predicted address leaving the window raises err on that beat instead of ack, then IDLE.
- next(adr,bte) works on word index w = adr[ADDR_WIDTH-1:OFF]:
  - linear: w+1.
  - wrap4: w[1:0]+1, upper bits held.
  - wrap8: w[2:0]+1, upper bits held.
  - wrap16: w[3:0]+1, upper bits held.
- Writes:
  - Committed on the rising edge where wb_ack_o=1 & wb_we_i=1, per byte lane where sel=1.
  - Read-during-write of the same word in the next beat returns the new data (write-first bypass).
- Simultaneous wb_ack_o and wb_err_o is never allowed.
- Reset asserted mid-burst: ack/err clear immediately (asynchronous). A beat in flight is not written.

Decomposition:
- Package mpsoc_dbg_wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16.
  - enum type for the FSM states {IDLE, BURST}.
- Sub-module mpsoc_dbg_wb_ram: synchronous single-port byte-enable RAM, DEPTH x DATA_WIDTH, 1-cycle read latency, no reset.
- Next-address logic is a function in the package.

Test Plan:
- Classic write to 0x10, dat=0xDEADBEEF, sel=1111, then classic read of 0x10 -> each ack is a 1-cycle pulse 1 cycle after stb; read returns 0xDEADBEEF; err stays 0.
- Byte-lane write to 0x10, sel=0010, dat=0x0000AA00, then read -> 0xDEADAAEF.
- Linear incrementing read burst from 0x20, 4 beats (010,010,010,111), RAM preloaded word k=k -> 1 wait cycle, then ack high 4 consecutive cycles with data 8,9,10,11; ack low next cycle.
- Wrap4 write burst starting 0x0C with data A,B,C,D -> addresses 0x0C,0x00,0x04,0x08 written; readback of 0x00..0x0C gives B,C,D,A.
- Classic read at BASE_ADDR+DEPTH*4, and a classic read at 0x02 -> each gives a single err pulse, no ack, RAM unchanged.
- wb_rst_i pulsed during beat 2 of a write burst -> ack=0 immediately; beat 2 word retains its old value; a following classic read works normally.

Source files
------------

// File: rtl/mpsoc_dbg_wb_pkg.sv
// Shared definitions for the debug Wishbone target memory.
//   - Wishbone B3 cycle-type (CTI) and burst-type (BTE) encodings
//   - FSM state type
//   - wb_next_widx(): next word index of an incrementing burst
package mpsoc_dbg_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic {IDLE, BURST} wb_state_e;

    // Word indices are carried at this fixed width so that a linear burst
    // stepping past the top of the address space is still seen as out of window.
    localparam int WIDX_W = 64;

    function automatic logic [WIDX_W-1:0] wb_next_widx(input logic [WIDX_W-1:0] w,
                                                       input logic [1:0]        bte);
        logic [WIDX_W-1:0] r;
        r = w;
        case (bte)
            BTE_LINEAR: r      = w + 64'd1;
            BTE_WRAP4:  r[1:0] = w[1:0] + 2'd1;
            BTE_WRAP8:  r[2:0] = w[2:0] + 3'd1;
            default:    r[3:0] = w[3:0] + 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mpsoc_dbg_wb_target_mem_if.sv
// Wishbone B3 bus bundle between the debug unit master and the target memory.
// Signal names carry the target's point of view (_i into the target, _o out).
//   master modport: drives cyc/stb/cti/bte/we/adr/sel/dat_i, sees dat_o/ack/err
//   slave  modport: the reverse
interface mpsoc_dbg_wb_target_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic [2:0]              wb_cti_i;
    logic [1:0]              wb_bte_i;
    logic                    wb_we_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;
    logic                    wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/mpsoc_dbg_wb_ram.sv
// Synchronous single-port RAM, DEPTH x DATA_WIDTH, byte enables, 1-cycle read.
// Write-first: a written byte lane is returned with its new value.
//   i_clk   clock
//   i_we    write strobe
//   i_sel   byte lane enables
//   i_addr  word address
//   i_wdat  write data
//   o_rdat  read data (registered, not reset)
module mpsoc_dbg_wb_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [NB-1:0]         i_sel,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdat,
    output logic [DATA_WIDTH-1:0] o_rdat
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we && i_sel[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
                o_rdat[b*8 +: 8]        <= i_wdat[b*8 +: 8];
            end else begin
                o_rdat[b*8 +: 8]        <= r_mem[i_addr][b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/mpsoc_dbg_wb_target_mem.sv
// Wishbone B3 target memory for the debug system: classic cycles with one wait
// state, zero-wait incrementing bursts (linear / wrap4/8/16), byte lanes, and
// err termination for out-of-window or misaligned addresses.
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   wb        slave side of the Wishbone bundle
module mpsoc_dbg_wb_target_mem
    import mpsoc_dbg_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    mpsoc_dbg_wb_target_mem_if.slave   wb
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NB);
    localparam int RAM_AW = $clog2(DEPTH);

    localparam logic [WIDX_W-1:0]     BASE64   = WIDX_W'(BASE_ADDR);
    localparam logic [WIDX_W-1:0]     LIMIT64  = BASE64 + WIDX_W'(DEPTH) * WIDX_W'(NB);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);

    function automatic logic hit(input logic [WIDX_W-1:0] a);
        return (a >= BASE64) && (a < LIMIT64);
    endfunction

    wb_state_e             r_state, w_state_nxt;
    logic                  r_ack, w_ack_nxt;
    logic                  r_err, w_err_nxt;
    // Byte address of the beat being acknowledged in the current cycle.
    logic [ADDR_WIDTH-1:0] r_pred, w_pred_nxt;

    logic                  w_req, w_good, w_cti_burst, w_beat_ok, w_wr, w_cont;
    logic [WIDX_W-1:0]     w_nxt64;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_rdat;

    assign w_req       = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
    assign w_good      = hit(WIDX_W'(wb.wb_adr_i)) && ((wb.wb_adr_i & OFF_MASK) == '0);
    assign w_cti_burst = (wb.wb_cti_i == CTI_INCR) || (wb.wb_cti_i == CTI_EOB);

    // The ack for this cycle was issued on a prediction; only a beat that
    // actually matches it is accepted (and may write).
    assign w_beat_ok = r_ack & wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i == r_pred)
                     & ((r_state == IDLE) | w_cti_burst);
    assign w_wr      = w_beat_ok & wb.wb_we_i;

    assign w_nxt64 = wb_next_widx(WIDX_W'(r_pred) >> OFF, wb.wb_bte_i) << OFF;
    assign w_cont  = (r_state == BURST) && w_beat_ok && (wb.wb_cti_i == CTI_INCR) && hit(w_nxt64);

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_pred_nxt  = r_pred;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_good) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_ack_nxt  = 1'b1;
                        w_pred_nxt = wb.wb_adr_i;
                        if (wb.wb_cti_i == CTI_INCR) w_state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                w_state_nxt = IDLE;
                if (w_cont) begin
                    w_ack_nxt   = 1'b1;
                    w_pred_nxt  = ADDR_WIDTH'(w_nxt64);
                    w_state_nxt = BURST;
                end else if (w_beat_ok && (wb.wb_cti_i == CTI_INCR)) begin
                    // burst would step out of the window
                    w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_pred  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_pred  <= w_pred_nxt;
        end
    end

    // Single port: writes use the accepted beat's address; during a read burst
    // the next word is prefetched so its data lines up with the next ack.
    always_comb begin
        w_ram_addr = wb.wb_adr_i[OFF +: RAM_AW];
        if (w_wr)        w_ram_addr = r_pred[OFF +: RAM_AW];
        else if (w_cont) w_ram_addr = w_nxt64[OFF +: RAM_AW];
    end

    mpsoc_dbg_wb_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk  (wb_clk_i),
        .i_we   (w_wr),
        .i_sel  (wb.wb_sel_i),
        .i_addr (w_ram_addr),
        .i_wdat (wb.wb_dat_i),
        .o_rdat (w_rdat)
    );

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign wb.wb_dat_o = r_ack ? w_rdat : '0;
endmodule

// File: tb/tb_mpsoc_dbg_wb_target_mem.sv
// Self-checking bench for mpsoc_dbg_wb_target_mem: drivers push expected
// responses into a scoreboard; a negedge monitor pops and compares them.
module tb_mpsoc_dbg_wb_target_mem;
    import mpsoc_dbg_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpsoc_dbg_wb_target_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mpsoc_dbg_wb_target_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus)
    );

    typedef struct {
        string       tag;
        logic        is_err;
        logic        has_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    logic [31:0] b_adr [8];
    logic [2:0]  b_cti [8];
    logic [31:0] b_dat [8];
    logic [31:0] b_rd  [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_resp(input string tag, input logic is_err, input logic has_dat,
                               input logic [31:0] dat);
        exp_t e;
        e.tag = tag; e.is_err = is_err; e.has_dat = has_dat; e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = CTI_CLASSIC;
        bus.wb_bte_i = BTE_LINEAR; bus.wb_we_i = 1'b0; bus.wb_adr_i = '0;
        bus.wb_sel_i = '0; bus.wb_dat_i = '0;
    endtask

    task automatic drive_beat(input int i, input logic we, input logic [1:0] bte);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_cti_i = b_cti[i];
        bus.wb_bte_i = bte; bus.wb_we_i = we; bus.wb_adr_i = b_adr[i];
        bus.wb_sel_i = 4'hF; bus.wb_dat_i = b_dat[i];
    endtask

    function automatic logic [31:0] resp();
        return 32'(bus.wb_ack_o | bus.wb_err_o);
    endfunction

    // Scoreboard monitor
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && (bus.wb_ack_o || bus.wb_err_o)) begin
            chk("ack_err_excl", 32'(bus.wb_ack_o & bus.wb_err_o), 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                chk({m_e.tag, "_kind"}, 32'(bus.wb_err_o), 32'(m_e.is_err));
                if (m_e.has_dat && !m_e.is_err) chk({m_e.tag, "_dat"}, bus.wb_dat_o, m_e.dat);
            end
        end
    end

    // Classic cycle: one wait state, one-cycle response pulse.
    task automatic wb_classic(input string tag, input logic we, input logic [31:0] adr,
                              input logic [3:0] sel, input logic [31:0] dat,
                              input logic exp_err, input logic [31:0] exp_dat);
        expect_resp(tag, exp_err, !we, exp_dat);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_cti_i = CTI_CLASSIC;
        bus.wb_bte_i = BTE_LINEAR; bus.wb_we_i = we; bus.wb_adr_i = adr;
        bus.wb_sel_i = sel; bus.wb_dat_i = dat;
        @(negedge clk); chk({tag, "_ws"},  resp(), 32'd0);
        @(negedge clk); chk({tag, "_rsp"}, resp(), 32'd1);
        @(posedge clk); #1; idle_bus();
        @(negedge clk); chk({tag, "_end"}, resp(), 32'd0);
    endtask

    // Burst of n beats from b_* tables; one wait state then zero-wait beats.
    task automatic wb_burst(input string tag, input logic we, input logic [1:0] bte,
                            input int n, input logic last_err);
        for (int i = 0; i < n; i++)
            expect_resp($sformatf("%s%0d", tag, i), (i == n-1) && last_err, !we, b_rd[i]);
        @(posedge clk); #1; drive_beat(0, we, bte);
        @(negedge clk); chk({tag, "_ws"}, resp(), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); chk($sformatf("%s_beat%0d", tag, i), resp(), 32'd1);
            @(posedge clk); #1;
            if (i + 1 < n) drive_beat(i + 1, we, bte);
            else           idle_bus();
        end
        @(negedge clk); chk({tag, "_end"}, resp(), 32'd0);
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_err", 32'(bus.wb_err_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        rst = 1'b0;

        // Classic write/read and byte lanes
        wb_classic("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        wb_classic("rd10", 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
        wb_classic("wb10", 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b0, 32'h0);
        wb_classic("rb10", 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF);

        // Preload words 8..15 with their index via a linear write burst
        for (int i = 0; i < 8; i++) begin
            b_adr[i] = 32'h20 + 32'(i) * 4; b_cti[i] = (i == 7) ? CTI_EOB : CTI_INCR;
            b_dat[i] = 32'(8 + i);          b_rd[i]  = 32'h0;
        end
        wb_burst("lwr", 1'b1, BTE_LINEAR, 8, 1'b0);

        // Linear read burst, 4 beats from 0x20
        for (int i = 0; i < 4; i++) begin
            b_adr[i] = 32'h20 + 32'(i) * 4; b_cti[i] = (i == 3) ? CTI_EOB : CTI_INCR;
            b_dat[i] = 32'h0;               b_rd[i]  = 32'(8 + i);
        end
        wb_burst("lrd", 1'b0, BTE_LINEAR, 4, 1'b0);

        // Wrap4 write burst from 0x0C
        b_adr[0] = 32'h0C; b_adr[1] = 32'h00; b_adr[2] = 32'h04; b_adr[3] = 32'h08;
        b_dat[0] = 32'hA0A0000A; b_dat[1] = 32'hB0B0000B; b_dat[2] = 32'hC0C0000C; b_dat[3] = 32'hD0D0000D;
        for (int i = 0; i < 4; i++) begin
            b_cti[i] = (i == 3) ? CTI_EOB : CTI_INCR; b_rd[i] = 32'h0;
        end
        wb_burst("w4wr", 1'b1, BTE_WRAP4, 4, 1'b0);
        wb_classic("w4rd0", 1'b0, 32'h00, 4'hF, 32'h0, 1'b0, 32'hB0B0000B);
        wb_classic("w4rd4", 1'b0, 32'h04, 4'hF, 32'h0, 1'b0, 32'hC0C0000C);
        wb_classic("w4rd8", 1'b0, 32'h08, 4'hF, 32'h0, 1'b0, 32'hD0D0000D);
        wb_classic("w4rdC", 1'b0, 32'h0C, 4'hF, 32'h0, 1'b0, 32'hA0A0000A);

        // Error terminations; RAM must be left untouched
        wb_classic("oow_rd", 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0);
        wb_classic("mis_rd", 1'b0, 32'h02,   4'hF, 32'h0, 1'b1, 32'h0);
        wb_classic("mis_wr", 1'b1, 32'h02,   4'hF, 32'h12345678, 1'b1, 32'h0);
        wb_classic("oow_wr", 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b1, 32'h0);
        wb_classic("mis_chk", 1'b0, 32'h00,  4'hF, 32'h0, 1'b0, 32'hB0B0000B);

        // Linear burst running off the top of the window: ack then err
        wb_classic("top_wr", 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        b_adr[0] = 32'hFFC;  b_cti[0] = CTI_INCR; b_dat[0] = 32'h0; b_rd[0] = 32'hCAFEF00D;
        b_adr[1] = 32'h1000; b_cti[1] = CTI_INCR; b_dat[1] = 32'h0; b_rd[1] = 32'h0;
        wb_burst("edge", 1'b0, BTE_LINEAR, 2, 1'b1);

        // Reset during the second beat of a write burst
        wb_classic("pre40", 1'b1, 32'h40, 4'hF, 32'h11110000, 1'b0, 32'h0);
        wb_classic("pre44", 1'b1, 32'h44, 4'hF, 32'h22220000, 1'b0, 32'h0);
        wb_classic("pre48", 1'b1, 32'h48, 4'hF, 32'h33330000, 1'b0, 32'h0);
        b_adr[0] = 32'h40; b_adr[1] = 32'h44; b_adr[2] = 32'h48;
        b_dat[0] = 32'hA1A1A1A1; b_dat[1] = 32'hA2A2A2A2; b_dat[2] = 32'hA3A3A3A3;
        b_cti[0] = CTI_INCR; b_cti[1] = CTI_INCR; b_cti[2] = CTI_EOB;
        expect_resp("rb0", 1'b0, 1'b0, 32'h0);
        expect_resp("rb1", 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1; drive_beat(0, 1'b1, BTE_LINEAR);
        @(negedge clk); chk("rb_ws", resp(), 32'd0);
        @(negedge clk); chk("rb_beat0", resp(), 32'd1);
        @(posedge clk); #1; drive_beat(1, 1'b1, BTE_LINEAR);
        @(negedge clk); chk("rb_beat1", resp(), 32'd1);
        #1; rst = 1'b1; idle_bus();
        #1;
        chk("rb_rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rb_rst_err", 32'(bus.wb_err_o), 32'd0);
        chk("rb_rst_dat", bus.wb_dat_o, 32'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        wb_classic("rb_rd40", 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'hA1A1A1A1);
        wb_classic("rb_rd44", 1'b0, 32'h44, 4'hF, 32'h0, 1'b0, 32'h22220000);
        wb_classic("rb_rd48", 1'b0, 32'h48, 4'hF, 32'h0, 1'b0, 32'h33330000);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
